hpm_sample_ctrl: RTL
====================

Name: hpm_sample_ctrl

Overview:
- Periodic sampling controller for the HPM counter bank. Shares the counter bank's single CSR access port between the core CSR unit and an internal sweep engine.
- On each sampling period, the sweep engine reads every enabled mhpmcounter and streams the values out on a valid/ready interface, e.g. to a trace/debug buffer.
- The core always has priority. The sampler only uses idle port cycles.

Parameters:
- CSR_ADDR_WIDTH, 12, CSR address width.
- XLEN, 64, data width; only 64 supported (elaboration error otherwise).
- HPM_NUM_COUNTERS, 29, number of implemented counters, indices 3..HPM_NUM_COUNTERS+2.
- PERIOD_WIDTH, 32, width of the sampling period timer.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- core_req_i  in  1  core is accessing the counter bank this cycle
- core_addr_i  in  CSR_ADDR_WIDTH  core CSR address
- core_we_i  in  1  core write enable
- core_data_i  in  XLEN  core write data
- core_data_o  out  XLEN  read data returned to the core
- hpm_addr_o  out  CSR_ADDR_WIDTH  address to counter bank
- hpm_we_o  out  1  write enable to counter bank
- hpm_data_o  out  XLEN  write data to counter bank
- hpm_data_i  in  XLEN  combinational read data from counter bank
- sample_en_i  in  1  enables periodic sweeps
- period_i  in  PERIOD_WIDTH  reload value of the period timer
- counter_mask_i  in  32  bit k set = sample counter k; bits 0..2 and bits above HPM_NUM_COUNTERS+2 are ignored
- count_ovf_i  in  1  overflow interrupt request from the counter bank
- smp_valid_o  out  1  sample beat valid
- smp_ready_i  in  1  sample beat accepted
- smp_idx_o  out  5  counter index of the beat
- smp_data_o  out  XLEN  sampled counter value
- smp_seq_o  out  16  sweep sequence number
- smp_last_o  out  1  last beat of the sweep
- overrun_o  out  1  one-cycle pulse: period expired while a sweep was still active

Behaviour:
- Port mux (combinational):
  - core_req_i=1: hpm_* = core_*, and core_data_o = hpm_data_i in the same cycle.
  - Otherwise: hpm_addr_o = CSR_MHPM_COUNTER_3 + (idx-3), hpm_we_o = 0, hpm_data_o = 0.
  - core_data_o is 0 whenever core_req_i=0.
- Reset: state IDLE, timer = 0, idx = 3, smp_seq_o = 0. All smp_* outputs are 0; overrun_o = 0.
- Timer:
  - Active only while sample_en_i=1. Counts down in all states; at 0 it expires and reloads period_i.
  - period_i=0 means it expires every cycle.
  - While sample_en_i=0 the timer is held at 0, so it expires on the first enabled cycle.
- FSM IDLE:
  - Timer expiry with a non-empty effective mask: idx := lowest set mask bit, go to READ.
  - Timer expiry with an empty effective mask: no sweep, no beat, smp_seq_o unchanged.
- FSM READ:
  - core_req_i=1: stall with no state change.
  - Otherwise, capture in one register update: smp_data_o := hpm_data_i, smp_idx_o := idx, smp_last_o := (no set mask bit above idx), smp_valid_o := 1. Go to HOLD.
- FSM HOLD:
  - smp_valid_o, smp_idx_o, smp_data_o, smp_last_o and smp_seq_o stay stable until smp_valid_o && smp_ready_i.
  - On handshake with smp_last_o=0: idx := next set mask bit, go to READ.
  - On handshake with smp_last_o=1: smp_seq_o := smp_seq_o+1 (wraps 0xFFFF→0), go to IDLE.
- Latency: expiry in cycle T → READ at T+1 → smp_valid_o=1 at T+2 if the core is idle. Maximum throughput is one beat per 2 cycles.
- Mask sampling: the mask is re-evaluated at each next-index computation. Bits cleared mid-sweep are skipped. A mask change never re-reads a lower index.
- sample_en_i deasserted mid-sweep: the current sweep completes.
- Timer expiry in READ/HOLD: no new sweep; overrun_o pulses for 1 cycle.
- Reset mid-sweep: the sweep is discarded immediately; smp_valid_o=0 in the next cycle.
- The sampler never writes the counter bank.

Optional Feature:
- Macro: HPM_SAMPLE_ON_OVF_EN.
- Defined: a count_ovf_i=1 cycle in IDLE starts a sweep exactly like a timer expiry, even with sample_en_i=0, and the timer reloads. count_ovf_i in READ/HOLD sets a pending flag; one sweep then starts on return to IDLE. count_ovf_i does not drive overrun_o.
- Undefined: count_ovf_i is ignored.

Decomposition:
- Shared package (riscv_pkg): CSR_MHPM_COUNTER_3 base address; hpm_smp_state_t enum (IDLE, READ, HOLD); HPM_FIRST_COUNTER=3.
- Sub-module hpm_next_idx: combinational priority encoder.
  - Inputs: effective mask, current idx.
  - Outputs: next set index above idx, lowest set index, any-above flag, mask-empty flag.

Test Plan:
- Basic sweep: mask=0x0000_0038, period=10, core idle, counters 3/4/5 = 0x11/0x22/0x33, ready tied 1 → beats (3,0x11), (4,0x22), (5,0x33,last); smp_seq_o=0, then 1 after the sweep.
- Core priority: core_req_i held for 5 cycles during READ → no beat; core_data_o equals the addressed counter each cycle; the beat appears 1 cycle after core_req_i drops.
- Backpressure/overrun: ready=0 for 20 cycles with period=3 → beat data stable throughout, overrun_o pulses each expiry, no second sweep starts.
- Empty and edge mask: mask=0x7 → no beats ever. Mask=0x8000_0000 with HPM_NUM_COUNTERS=29 → single beat idx=31 with last=1.
- Reset/disable: rst_i mid-HOLD → smp_valid_o=0 next cycle, smp_seq_o=0. sample_en_i dropped mid-sweep → the sweep still finishes with last.
- HPM_SAMPLE_ON_OVF_EN: sample_en_i=0, count_ovf_i pulse → one full sweep. A pulse arriving during the sweep → exactly one extra sweep afterwards.

Source files
------------

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the HPM sampling controller.
//   CSR_MHPM_COUNTER_3 : CSR address of mhpmcounter3, base of the counter bank
//   HPM_FIRST_COUNTER  : index of the first implemented programmable counter
//   hpm_smp_state_t    : sweep engine state (IDLE, READ, HOLD)
//   hpm_valid_mask()   : bit k set for every implemented counter index k
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [11:0] CSR_MHPM_COUNTER_3 = 12'hB03;
    localparam int          HPM_FIRST_COUNTER  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } hpm_smp_state_t;

    // Implemented counters occupy indices 3 .. num_counters+2.
    function automatic logic [31:0] hpm_valid_mask(input int num_counters);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 32; k++) begin
            if (k >= HPM_FIRST_COUNTER && k < HPM_FIRST_COUNTER + num_counters) begin
                m[k] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/hpm_next_idx.sv
// -----------------------------------------------------------------------------
// hpm_next_idx
// Combinational priority encoder over the effective counter mask.
// Ports:
//   mask      in  32  effective sample mask (already restricted to valid counters)
//   idx       in  5   current counter index
//   next_idx  out 5   lowest set index strictly above idx (0 if none)
//   low_idx   out 5   lowest set index in the mask (0 if empty)
//   any_above out 1   some mask bit above idx is set
//   empty     out 1   mask has no bit set
// -----------------------------------------------------------------------------
module hpm_next_idx (
    input  logic [31:0] mask,
    input  logic [4:0]  idx,
    output logic [4:0]  next_idx,
    output logic [4:0]  low_idx,
    output logic        any_above,
    output logic        empty
);

    // Scan from the top down so the last hit written is the lowest one.
    always_comb begin
        next_idx  = 5'd0;
        low_idx   = 5'd0;
        any_above = 1'b0;
        for (int k = 31; k >= 0; k--) begin
            if (mask[k]) begin
                low_idx = 5'(k);
                if (5'(k) > idx) begin
                    next_idx  = 5'(k);
                    any_above = 1'b1;
                end
            end
        end
    end

    assign empty = (mask == 32'd0);

endmodule

// File: rtl/hpm_sample_ctrl.sv
// -----------------------------------------------------------------------------
// hpm_sample_ctrl
// Periodic sampling controller for the HPM counter bank. The bank's single
// CSR port is shared between the core (always wins) and a sweep engine that
// reads every enabled mhpmcounter once per sampling period and streams the
// values out as beats.
//
// Optional feature macro: HPM_SAMPLE_ON_OVF_EN
//   defined   : count_ovf_i also starts a sweep (pending flag while busy)
//   undefined : count_ovf_i is ignored
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   core_req_i/addr/we/data_i, core_data_o   core CSR access
//   hpm_addr_o/we_o/data_o, hpm_data_i       counter bank port
//   sample_en_i, period_i                    period timer control
//   counter_mask_i                           bit k selects counter k
//   count_ovf_i                              counter overflow request
//   smp_valid_o/ready_i/idx_o/data_o/seq_o/last_o   sample beat stream
//   overrun_o                                period expired mid-sweep
//
// Handshake: a beat transfers on a cycle where smp_valid_o && smp_ready_i.
// Once smp_valid_o rises, it and all beat fields stay stable until that
// transfer; smp_valid_o never drops without a transfer (except on reset).
// -----------------------------------------------------------------------------
module hpm_sample_ctrl
    import riscv_pkg::*;
#(
    parameter int CSR_ADDR_WIDTH   = 12,
    parameter int XLEN             = 64,
    parameter int HPM_NUM_COUNTERS = 29,
    parameter int PERIOD_WIDTH     = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      core_req_i,
    input  logic [CSR_ADDR_WIDTH-1:0] core_addr_i,
    input  logic                      core_we_i,
    input  logic [XLEN-1:0]           core_data_i,
    output logic [XLEN-1:0]           core_data_o,
    output logic [CSR_ADDR_WIDTH-1:0] hpm_addr_o,
    output logic                      hpm_we_o,
    output logic [XLEN-1:0]           hpm_data_o,
    input  logic [XLEN-1:0]           hpm_data_i,
    input  logic                      sample_en_i,
    input  logic [PERIOD_WIDTH-1:0]   period_i,
    input  logic [31:0]               counter_mask_i,
    input  logic                      count_ovf_i,
    output logic                      smp_valid_o,
    input  logic                      smp_ready_i,
    output logic [4:0]                smp_idx_o,
    output logic [XLEN-1:0]           smp_data_o,
    output logic [15:0]               smp_seq_o,
    output logic                      smp_last_o,
    output logic                      overrun_o
);

    if (XLEN != 64) begin : g_xlen_check
        $error("hpm_sample_ctrl: only XLEN=64 is supported");
    end
    if (HPM_NUM_COUNTERS < 1 || HPM_NUM_COUNTERS > 29) begin : g_num_check
        $error("hpm_sample_ctrl: HPM_NUM_COUNTERS must be 1..29");
    end

    localparam logic [31:0] VALID_MASK = hpm_valid_mask(HPM_NUM_COUNTERS);

    // FSM state is kept as a named enum so checkers can bind to it directly.
    hpm_smp_state_t          state, state_next;
    logic [PERIOD_WIDTH-1:0] timer;
    logic [4:0]              idx, idx_next;

    logic                    valid_next;
    logic [4:0]              sidx_next;
    logic [XLEN-1:0]         sdata_next;
    logic                    last_next;
    logic [15:0]             seq_next;

    logic [31:0]             eff_mask;
    logic [4:0]              nx_next;
    logic [4:0]              nx_low;
    logic                    nx_any_above;
    logic                    nx_empty;

    logic                    expiry;
    logic                    start_req;
    logic                    ovf_reload;

    assign eff_mask = counter_mask_i & VALID_MASK;
    assign expiry   = sample_en_i && (timer == '0);

    hpm_next_idx u_next_idx (
        .mask      (eff_mask),
        .idx       (idx),
        .next_idx  (nx_next),
        .low_idx   (nx_low),
        .any_above (nx_any_above),
        .empty     (nx_empty)
    );

`ifdef HPM_SAMPLE_ON_OVF_EN
    // Overflow requests seen while busy are remembered (once) and serviced
    // as soon as the engine is back in IDLE.
    logic ovf_pending;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_pending <= 1'b0;
        end else if (state == IDLE) begin
            ovf_pending <= 1'b0;
        end else if (count_ovf_i) begin
            ovf_pending <= 1'b1;
        end
    end

    assign start_req  = expiry || count_ovf_i || ovf_pending;
    assign ovf_reload = (state == IDLE) && (count_ovf_i || ovf_pending);
`else
    logic unused_ovf;
    assign unused_ovf = count_ovf_i;
    assign start_req  = expiry;
    assign ovf_reload = 1'b0;
`endif

    // Period timer: held at 0 while disabled so the first enabled cycle
    // expires immediately; a reload value of N gives one expiry every N+1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer <= '0;
        end else if (!sample_en_i) begin
            timer <= '0;
        end else if (expiry || ovf_reload) begin
            timer <= period_i;
        end else begin
            timer <= timer - PERIOD_WIDTH'(1);
        end
    end

    // Port mux: the core owns the port whenever it requests it; otherwise the
    // sweep engine presents the address of the current counter, read-only.
    always_comb begin
        if (core_req_i) begin
            hpm_addr_o  = core_addr_i;
            hpm_we_o    = core_we_i;
            hpm_data_o  = core_data_i;
            core_data_o = hpm_data_i;
        end else begin
            hpm_addr_o  = CSR_ADDR_WIDTH'(CSR_MHPM_COUNTER_3)
                        + CSR_ADDR_WIDTH'(idx - 5'(HPM_FIRST_COUNTER));
            hpm_we_o    = 1'b0;
            hpm_data_o  = '0;
            core_data_o = '0;
        end
    end

    // Next-state and beat register logic.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        valid_next = smp_valid_o;
        sidx_next  = smp_idx_o;
        sdata_next = smp_data_o;
        last_next  = smp_last_o;
        seq_next   = smp_seq_o;
        case (state)
            IDLE: begin
                if (start_req && !nx_empty) begin
                    idx_next   = nx_low;
                    state_next = READ;
                end
            end
            READ: begin
                // The read only happens on a cycle the core leaves idle.
                if (!core_req_i) begin
                    sdata_next = hpm_data_i;
                    sidx_next  = idx;
                    last_next  = !nx_any_above;
                    valid_next = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (smp_valid_o && smp_ready_i) begin
                    valid_next = 1'b0;
                    // The mask is re-read here; if every higher bit has been
                    // cleared since the beat was built, the sweep just ends.
                    if (!smp_last_o && nx_any_above) begin
                        idx_next   = nx_next;
                        state_next = READ;
                    end else begin
                        seq_next   = smp_seq_o + 16'd1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            idx         <= 5'(HPM_FIRST_COUNTER);
            smp_valid_o <= 1'b0;
            smp_idx_o   <= 5'd0;
            smp_data_o  <= '0;
            smp_last_o  <= 1'b0;
            smp_seq_o   <= 16'd0;
            overrun_o   <= 1'b0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            smp_valid_o <= valid_next;
            smp_idx_o   <= sidx_next;
            smp_data_o  <= sdata_next;
            smp_last_o  <= last_next;
            smp_seq_o   <= seq_next;
            overrun_o   <= expiry && (state != IDLE);
        end
    end

endmodule
